// File: rtl/c2_pkg.sv
// Shared constants and types for the C2 arbiter and its UART memory loader.
// The loader checksum option is selected with the LOADER_CHECKSUM_EN macro.
package c2_pkg;

    localparam logic [7:0] CMD_LOAD_IMEM = 8'h1C;
    localparam logic [7:0] CMD_LOAD_DMEM = 8'h1D;
    localparam logic [7:0] CMD_RUN       = 8'hCE;
    localparam logic [7:0] CMD_DEBUG     = 8'hDE;

    localparam logic [7:0] LOADER_ACK = 8'hAC;
    localparam logic [7:0] LOADER_NAK = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_TX_STATUS,
        S_WAIT_TX,
        S_DONE,
        S_RELEASE
    } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs four little-endian bytes into a 32-bit word; word_valid_o pulses the
// cycle after the fourth byte, while word_o still holds that word.
module loader_word_assembler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;
    logic        word_valid_q;

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the datapath register is reset too, so mem_wdata_o reads 0 out of reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            byte_cnt_q   <= 2'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (clear_i) begin
                byte_cnt_q <= 2'd0;
            end else if (byte_valid_i) begin
                word_q       <= {byte_i, word_q[31:8]};
                byte_cnt_q   <= byte_cnt_q + 2'd1;
                word_valid_q <= (byte_cnt_q == 2'd3);
            end
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/uart_mem_loader.sv
// Loads a length-prefixed word stream from the host UART into IMEM or DMEM.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_mem_loader
    import c2_pkg::*;
#(
    parameter int MEM_WORDS      = 256,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              grant_i,
    input  logic              target_i,
    input  logic [7:0]        uart_rx_data_i,
    input  logic              uart_rx_ready_i,
    input  logic              uart_tx_done_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    output logic              imem_we_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              done_o
);

    localparam int          IDX_W = $clog2(MEM_WORDS) + 1;
    localparam int          TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_N = 17'(MEM_WORDS);

    loader_state_t    state_q, state_d;
    logic             grant_q;
    logic             target_q, target_d;
    logic [15:0]      count_q, count_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [7:0]       status_q, status_d;
    logic [TO_W-1:0]  idle_q, idle_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    logic        rx_active, timeout, last_word, mem_we, tx_start, done;
    logic        asm_valid;
    logic [31:0] asm_word;
    logic [15:0] len_n;

    loader_word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (state_q != S_DATA),
        .byte_valid_i (uart_rx_ready_i && state_q == S_DATA),
        .byte_i       (uart_rx_data_i),
        .word_valid_o (asm_valid),
        .word_o       (asm_word)
    );

    assign len_n     = {uart_rx_data_i, count_q[7:0]};
    assign last_word = (16'(word_idx_q) + 16'd1 == count_q);
    assign rx_active = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CHECK);
    assign timeout   = rx_active && !uart_rx_ready_i &&
                       (idle_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign idle_d    = (rx_active && !uart_rx_ready_i) ? idle_q + TO_W'(1) : '0;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        status_d   = status_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        mem_we     = 1'b0;
        tx_start   = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            S_IDLE: if (grant_i && !grant_q) begin
                target_d   = target_i;
                count_d    = 16'd0;
                word_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
                chk_d      = 8'd0;
`endif
                state_d    = S_LEN_LO;
            end
            S_LEN_LO: if (uart_rx_ready_i) begin
                count_d[7:0] = uart_rx_data_i;
`ifdef LOADER_CHECKSUM_EN
                chk_d        = chk_q ^ uart_rx_data_i;
`endif
                state_d      = S_LEN_HI;
            end else if (timeout) begin
                status_d = LOADER_NAK;
                state_d  = S_TX_STATUS;
            end
            S_LEN_HI: if (uart_rx_ready_i) begin
                count_d  = len_n;
`ifdef LOADER_CHECKSUM_EN
                chk_d    = chk_q ^ uart_rx_data_i;
`endif
                status_d = LOADER_ACK;
                if ({1'b0, len_n} > MAX_N) begin
                    status_d = LOADER_NAK;
                    state_d  = S_TX_STATUS;
                end else if (len_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_TX_STATUS;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end else if (timeout) begin
                status_d = LOADER_NAK;
                state_d  = S_TX_STATUS;
            end
            S_DATA: begin
                if (asm_valid) begin
                    mem_we     = 1'b1;
                    word_idx_d = word_idx_q + IDX_W'(1);
                end
                if (asm_valid && last_word) begin
                    status_d = LOADER_ACK;
`ifdef LOADER_CHECKSUM_EN
                    // A checksum byte landing on the final write cycle is consumed here.
                    if (uart_rx_ready_i) begin
                        status_d = (uart_rx_data_i == chk_q) ? LOADER_ACK : LOADER_NAK;
                        state_d  = S_TX_STATUS;
                    end else begin
                        state_d  = S_CHECK;
                    end
`else
                    state_d  = S_TX_STATUS;
`endif
                end else if (uart_rx_ready_i) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ uart_rx_data_i;
`endif
                end else if (timeout) begin
                    status_d = LOADER_NAK;
                    state_d  = S_TX_STATUS;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: if (uart_rx_ready_i) begin
                status_d = (uart_rx_data_i == chk_q) ? LOADER_ACK : LOADER_NAK;
                state_d  = S_TX_STATUS;
            end else if (timeout) begin
                status_d = LOADER_NAK;
                state_d  = S_TX_STATUS;
            end
`endif
            S_TX_STATUS: begin
                tx_start = 1'b1;
                state_d  = S_WAIT_TX;
            end
            S_WAIT_TX: if (uart_tx_done_i) state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_RELEASE;
            end
            S_RELEASE: if (!grant_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Losing the grant mid-transfer abandons it silently, including a write due now.
        if (!grant_i && state_q != S_IDLE && state_q != S_RELEASE) begin
            state_d  = S_IDLE;
            mem_we   = 1'b0;
            tx_start = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b0;
            target_q   <= 1'b0;
            count_q    <= 16'd0;
            word_idx_q <= '0;
            status_q   <= 8'd0;
            idle_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_i;
            target_q   <= target_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            status_q   <= status_d;
            idle_q     <= idle_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign imem_we_o   = mem_we && !target_q;
    assign dmem_we_o   = mem_we && target_q;
    assign mem_addr_o  = ADDR_W'({word_idx_q, 2'b00});
    assign mem_wdata_o = asm_word;
    assign tx_start_o  = tx_start;
    assign done_o      = done;
    assign tx_data_o   = (state_q == S_TX_STATUS || state_q == S_WAIT_TX) ? status_q : 8'd0;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: table vectors, corner sequences and
// random transfers checked against a byte-stream reference model.
module tb_uart_mem_loader;
    import c2_pkg::*;

    localparam int MEM_WORDS = 256;
    localparam int TIMEOUT   = 100;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni, grant_i, target_i, uart_rx_ready_i, uart_tx_done_i;
    logic [7:0]  uart_rx_data_i, tx_data_o;
    logic        tx_start_o, imem_we_o, dmem_we_o, done_o;
    logic [31:0] mem_addr_o, mem_wdata_o;

    always #5 clk_i = ~clk_i;

    uart_mem_loader #(
        .MEM_WORDS      (MEM_WORDS),
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .grant_i         (grant_i),
        .target_i        (target_i),
        .uart_rx_data_i  (uart_rx_data_i),
        .uart_rx_ready_i (uart_rx_ready_i),
        .uart_tx_done_i  (uart_tx_done_i),
        .tx_data_o       (tx_data_o),
        .tx_start_o      (tx_start_o),
        .imem_we_o       (imem_we_o),
        .dmem_we_o       (dmem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .done_o          (done_o)
    );

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef wr_t        wq_t[$];
    typedef logic [7:0] bq_t[$];

    typedef struct {
        string       name;
        bit          tgt;
        logic [15:0] n;
        int          pay;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  exp_st;
        int          exp_wr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: records every write strobe, TX start and done pulse.
    wr_t        wlog[$];
    int         tx_starts = 0;
    int         dones     = 0;
    int         both_we   = 0;
    logic [7:0] last_tx   = 8'd0;

    always @(negedge clk_i) begin
        if (imem_we_o || dmem_we_o) wlog.push_back('{dmem_we_o, mem_addr_o, mem_wdata_o});
        if (imem_we_o && dmem_we_o) both_we <= both_we + 1;
        if (tx_start_o) begin
            tx_starts <= tx_starts + 1;
            last_tx   <= tx_data_o;
        end
        if (done_o) dones <= dones + 1;
    end

    // Reference model: what the host stream should produce, from the protocol rules.
    function automatic void model(input bit tgt, input bq_t b, output wq_t ew, output logic [7:0] est);
        int         n;
        logic [7:0] x;
        ew  = {};
        est = LOADER_NAK;
        if (b.size() < 2) return;
        n = int'(b[0]) | (int'(b[1]) << 8);
        if (n > MEM_WORDS) return;
        for (int i = 0; i < n && 2 + 4 * i + 3 < b.size(); i++)
            ew.push_back('{tgt, 32'(4 * i),
                           {b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]}});
        if (CHK) begin
            if (b.size() >= 3 + 4 * n) begin
                x = 8'd0;
                for (int i = 0; i < 2 + 4 * n; i++) x ^= b[i];
                est = (x == b[2+4*n]) ? LOADER_ACK : LOADER_NAK;
            end
        end else if (b.size() >= 2 + 4 * n) begin
            est = LOADER_ACK;
        end
    endfunction

    function automatic bq_t build(input logic [15:0] n, input int pay, input logic [31:0] w0,
                                  input logic [31:0] w1, input logic [7:0] chk_err);
        bq_t         b;
        logic [31:0] w;
        logic [7:0]  x;
        b.push_back(n[7:0]);
        b.push_back(n[15:8]);
        for (int i = 0; i < pay; i++) begin
            w = (i < 4) ? w0 : (i < 8) ? w1 : w0 ^ (32'(i / 4) * 32'h9E3779B9);
            b.push_back(w[8*(i%4) +: 8]);
        end
        if (CHK && pay == 4 * int'(n) && int'(n) <= MEM_WORDS) begin
            x = 8'd0;
            foreach (b[k]) x ^= b[k];
            b.push_back(x ^ chk_err);
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        uart_rx_data_i  = v;
        uart_rx_ready_i = 1'b1;
        tick();
        uart_rx_ready_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic run_transfer(input string tag, input bit tgt, input bq_t b, input bit rand_gaps,
                                output logic [7:0] got_st, output int got_wr);
        wq_t        ew;
        logic [7:0] est;
        int         w0, t0, d0, nw;
        bit         seen;
        model(tgt, b, ew, est);
        w0 = wlog.size();
        t0 = tx_starts;
        d0 = dones;
        target_i = tgt;
        grant_i  = 1'b1;
        tick();
        foreach (b[i]) send_byte(b[i], rand_gaps ? int'($urandom_range(0, 2)) : 0);
        seen = 1'b0;
        for (int c = 0; c < TIMEOUT + 50 && !seen; c++) begin
            tick();
            if (tx_starts != t0) seen = 1'b1;
        end
        check({tag, " tx_start seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " tx_data held"}, 32'(tx_data_o), 32'(est));
            check({tag, " status byte"}, 32'(last_tx), 32'(est));
            uart_tx_done_i = 1'b1;
            tick();
            uart_tx_done_i = 1'b0;
            repeat (4) tick();
            check({tag, " done pulses"}, 32'(dones - d0), 32'd1);
        end
        check({tag, " tx_start count"}, 32'(tx_starts - t0), 32'd1);
        nw = wlog.size() - w0;
        check({tag, " write count"}, 32'(nw), 32'(ew.size()));
        for (int i = 0; i < nw && i < ew.size(); i++) begin
            check($sformatf("%s w%0d sel", tag, i),  32'(wlog[w0+i].sel), 32'(ew[i].sel));
            check($sformatf("%s w%0d addr", tag, i), wlog[w0+i].addr, ew[i].addr);
            check($sformatf("%s w%0d data", tag, i), wlog[w0+i].data, ew[i].data);
        end
        grant_i = 1'b0;
        repeat (2) tick();
        got_st = last_tx;
        got_wr = nw;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        bq_t        b;
        logic [7:0] st, chk_err;
        int         wr, w0, t0, d0, kind;
        logic [15:0] n;
        int         pay;
        bit         tgt;

        vecs[0] = '{"two_words_imem", 1'b0, 16'd2,   8,  32'h12345678, 32'hDEADBEEF, LOADER_ACK, 2};
        vecs[1] = '{"zero_dmem",      1'b1, 16'd0,   0,  32'h0,        32'h0,        LOADER_ACK, 0};
        vecs[2] = '{"too_long",       1'b0, 16'd257, 0,  32'h0,        32'h0,        LOADER_NAK, 0};
        vecs[3] = '{"timeout",        1'b0, 16'd1,   2,  32'hCAFEF00D, 32'h0,        LOADER_NAK, 0};
        vecs[4] = '{"one_dmem",       1'b1, 16'd1,   4,  32'hCAFEF00D, 32'h0,        LOADER_ACK, 1};
        vecs[5] = '{"three_dmem",     1'b1, 16'd3,   12, 32'h0BADC0DE, 32'h00000001, LOADER_ACK, 3};

        rst_ni = 1'b0; grant_i = 1'b0; target_i = 1'b0;
        uart_rx_data_i = 8'd0; uart_rx_ready_i = 1'b0; uart_tx_done_i = 1'b0;
        repeat (3) tick();
        check("reset strobes", {27'd0, tx_start_o, imem_we_o, dmem_we_o, done_o, 1'b0}, 32'd0);
        check("reset tx_data", 32'(tx_data_o), 32'd0);
        check("reset addr", mem_addr_o, 32'd0);
        check("reset wdata", mem_wdata_o, 32'd0);
        rst_ni = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 6; v++) begin
            b = build(vecs[v].n, vecs[v].pay, vecs[v].w0, vecs[v].w1, 8'd0);
            run_transfer(vecs[v].name, vecs[v].tgt, b, 1'b0, st, wr);
            check({vecs[v].name, " table status"}, 32'(st), 32'(vecs[v].exp_st));
            check({vecs[v].name, " table writes"}, 32'(wr), 32'(vecs[v].exp_wr));
        end

        // Grant dropped after three payload bytes: nothing may happen.
        w0 = wlog.size(); t0 = tx_starts; d0 = dones;
        target_i = 1'b0; grant_i = 1'b1; tick();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        grant_i = 1'b0;
        repeat (10) tick();
        // Grant dropped exactly in the cycle the write would strobe.
        grant_i = 1'b1; tick();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        grant_i = 1'b0;
        repeat (10) tick();
        check("drop writes", 32'(wlog.size() - w0), 32'd0);
        check("drop tx_start", 32'(tx_starts - t0), 32'd0);
        check("drop done", 32'(dones - d0), 32'd0);
        b = build(16'd1, 4, 32'h55AA33CC, 32'h0, 8'd0);
        run_transfer("after_drop", 1'b0, b, 1'b0, st, wr);
        check("after_drop status", 32'(st), 32'(LOADER_ACK));

        // Largest accepted length, back-to-back bytes.
        b = build(16'(MEM_WORDS), 4 * MEM_WORDS, 32'h89ABCDEF, 32'h76543210, 8'd0);
        run_transfer("full_mem", 1'b1, b, 1'b0, st, wr);
        check("full_mem writes", 32'(wr), 32'(MEM_WORDS));

`ifdef LOADER_CHECKSUM_EN
        b = '{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h05};
        run_transfer("chk_good", 1'b0, b, 1'b0, st, wr);
        check("chk_good status", 32'(st), 32'(LOADER_ACK));
        b[6] = 8'h00;
        run_transfer("chk_bad", 1'b0, b, 1'b0, st, wr);
        check("chk_bad status", 32'(st), 32'(LOADER_NAK));
        check("chk_bad write kept", 32'(wr), 32'd1);
`endif

        for (int r = 0; r < 12; r++) begin
            tgt     = 1'($urandom_range(0, 1));
            kind    = int'($urandom_range(0, 5));
            chk_err = 8'd0;
            if (kind == 0) begin
                n   = 16'($urandom_range(MEM_WORDS + 1, 65535));
                pay = 0;
            end else begin
                n   = 16'($urandom_range(0, 6));
                pay = 4 * int'(n);
                if (kind == 1 && n != 0) pay = int'($urandom_range(0, 4 * int'(n) - 1));
                if (CHK && kind == 2) chk_err = 8'($urandom_range(1, 255));
            end
            b = build(n, pay, $urandom, $urandom, chk_err);
            run_transfer($sformatf("rand%0d", r), tgt, b, 1'b1, st, wr);
        end

        check("never both write enables", 32'(both_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Downstream of the C2 arbiter; active only while the arbiter grants loader access.
- Receives a length-prefixed word stream from the host UART and writes it into IMEM or DMEM, selected by the target input.
- Reports completion with a status byte on its UART TX tap, then pulses done so the arbiter runs its cleanup sequence.

Parameters:
- MEM_WORDS, 256, capacity of the target memory in 32-bit words; word counts above this are rejected.
- ADDR_W, 32, width of the byte address output.
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed between received bytes before the transfer aborts.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, synchronous, active-low
- grant_i  in  1  loader grant from arbiter
- target_i  in  1  0 = IMEM, 1 = DMEM; sampled on grant rise
- uart_rx_data_i  in  8  received byte
- uart_rx_ready_i  in  1  one-cycle strobe, byte valid
- uart_tx_done_i  in  1  one-cycle strobe, TX byte finished
- tx_data_o  out  8  status byte to arbiter TX mux
- tx_start_o  out  1  one-cycle TX start strobe
- imem_we_o  out  1  IMEM write enable
- dmem_we_o  out  1  DMEM write enable
- mem_addr_o  out  ADDR_W  byte address (word-aligned)
- mem_wdata_o  out  32  write data
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_ni low at a clk_i edge): state S_IDLE; all outputs 0; counters cleared.
- Host protocol after grant:
  - Word count N: 2 bytes, little-endian.
  - Payload: N words, 4 bytes each, little-endian.
  - Response: status byte 0xAC (ACK) or 0xEE (NAK).
- States and transitions:
  - S_IDLE: on grant_i rising (grant high, previous cycle low), latch target_i and go to S_LEN_LO.
  - S_LEN_LO / S_LEN_HI: capture the count bytes.
    - N > MEM_WORDS → S_TX_STATUS with NAK.
    - N = 0 → S_TX_STATUS with ACK.
    - Otherwise → S_DATA.
  - S_DATA: assemble bytes into a 32-bit word; byte 0 goes to [7:0].
    - On the cycle after the 4th byte's rx_ready, assert exactly one of imem_we_o/dmem_we_o for one cycle, with mem_addr_o = word_idx*4 and the assembled word on mem_wdata_o.
    - word_idx starts at 0 and increments after each write.
    - After write N-1 → S_TX_STATUS.
  - S_TX_STATUS: drive tx_data_o; pulse tx_start_o for one cycle; go to S_WAIT_TX.
  - S_WAIT_TX: on uart_tx_done_i → S_DONE.
  - S_DONE: done_o = 1 for one cycle → S_RELEASE.
  - S_RELEASE: wait for grant_i low → S_IDLE. This prevents a re-trigger while the arbiter is still in cleanup.
- tx_data_o holds the status byte from S_TX_STATUS through S_WAIT_TX; it is 0 otherwise.
- Timeout: the idle counter resets on every rx_ready in S_LEN_LO, S_LEN_HI and S_DATA. When it reaches TIMEOUT_CYCLES, go to S_TX_STATUS with NAK. Words already written stay written.
- Grant drop mid-operation (grant_i low in any state other than S_IDLE or S_RELEASE): go to S_IDLE next cycle. No further writes, no TX, no done pulse. A write strobe already due in that same cycle is suppressed.
- rx_ready outside S_LEN_LO, S_LEN_HI and S_DATA is ignored.
- rx_ready in the same cycle as a write strobe is accepted as byte 0 of the next word.
- word_idx is $clog2(MEM_WORDS)+1 bits; address = word_idx << 2, zero-extended to ADDR_W.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - The host appends 1 checksum byte after the payload (also after N = 0): the XOR of both count bytes and all payload bytes.
  - A new state S_CHECK receives it; the timeout also applies in S_CHECK.
  - Match → ACK 0xAC; mismatch → NAK 0xEE. Writes are not rolled back.
- Undefined: no checksum byte; ACK follows the last write directly.

Decomposition:
- Package c2_pkg holds:
  - command codes 0x1C, 0x1D, 0xCE, 0xDE;
  - LOADER_ACK = 8'hAC and LOADER_NAK = 8'hEE;
  - the loader_state_t enum.
- One sub-module, loader_word_assembler:
  - a 2-bit byte counter and 32-bit shift register;
  - outputs word_valid (one cycle) and word;
  - clear input driven by the FSM.

Test Plan:
- target = 0; bytes 02 00, 78 56 34 12, EF BE AD DE → imem_we pulses at addr 0x0 data 0x12345678, then addr 0x4 data 0xDEADBEEF; dmem_we stays 0; TX 0xAC; one done pulse after tx_done.
- target = 1; bytes 00 00 → no writes; TX 0xAC; done pulses once.
- MEM_WORDS = 256; bytes 01 01 (N = 257) → no writes; TX 0xEE; done pulses.
- N = 1; send 2 payload bytes, then idle TIMEOUT_CYCLES (bench sets 100) → TX 0xEE; no write.
- grant_i dropped after 3 payload bytes → no write; no tx_start; no done; state returns to S_IDLE; a new grant starts a fresh transfer at addr 0.
- LOADER_CHECKSUM_EN: N = 1, word 0x01020304 with checksum 0x05 → ACK 0xAC; same word with checksum 0x00 → NAK 0xEE, but the write has still occurred.
